// File: rtl/jt8255_peer_if.sv
// Handshake and stream signals between jt8255_peer and its surroundings.
// The slave modport is the peer engine; master is the jt8255/source/sink side.
interface jt8255_peer_if #(
    parameter int FIFO_AW = 2
);
    logic             obf_n;
    logic             ibf;
    logic [7:0]       pa_din;
    logic [7:0]       pa_dout;
    logic             pa_oe;
    logic             ack_n;
    logic             stb_n;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [FIFO_AW:0] rx_level;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    modport slave (
        input  obf_n, ibf, pa_din, rx_ready, tx_data, tx_valid,
        output pa_dout, pa_oe, ack_n, stb_n, rx_data, rx_valid, rx_level, tx_ready
    );

    modport master (
        output obf_n, ibf, pa_din, rx_ready, tx_data, tx_valid,
        input  pa_dout, pa_oe, ack_n, stb_n, rx_data, rx_valid, rx_level, tx_ready
    );
endinterface

// File: rtl/jt8255_peer.sv
// Peripheral-side jt8255 Port A strobed handshake: OBF/ACK capture into a
// FWFT receive FIFO, and STB/IBF presentation of bytes from a valid/ready source.
module jt8255_peer #(
    parameter int ACK_W   = 2,
    parameter int STB_W   = 2,
    parameter int FIFO_AW = 2
) (
    input  logic clk,
    input  logic rst,
    jt8255_peer_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int MAXW  = (ACK_W > STB_W) ? ACK_W : STB_W;
    localparam int CW    = $clog2(MAXW) + 1;

    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      ACK_LOAD = CW'(ACK_W - 1);
    localparam logic [CW-1:0]      STB_LOAD = CW'(STB_W - 1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] { R_IDLE, R_ACK, R_WAIT } rx_state_t;
    typedef enum logic [1:0] { T_IDLE, T_STB, T_HOLD } tx_state_t;

    rx_state_t          rx_st;
    tx_state_t          tx_st;
    logic [CW-1:0]      rcnt;
    logic [CW-1:0]      tcnt;
    logic               saw_ibf;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level;
    logic               full;
    logic               push;
    logic               pop;

    // Fullness is taken before this cycle's pop, so a full FIFO never pushes.
    assign full = (level == LVL_FULL);
    assign push = (rx_st == R_IDLE) && !bus.obf_n && !full;
    assign pop  = (level != '0) && bus.rx_ready;

    assign bus.rx_data  = mem[rd_ptr];
    assign bus.rx_valid = (level != '0);
    assign bus.rx_level = level;
    assign bus.tx_ready = (tx_st == T_IDLE) && !bus.ibf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st     <= R_IDLE;
            rcnt      <= '0;
            bus.ack_n <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.pa_din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      level <= level + LVL_ONE;
            else if (pop && !push) level <= level - LVL_ONE;

            case (rx_st)
                R_IDLE: if (push) begin
                    bus.ack_n <= 1'b0;
                    rcnt      <= ACK_LOAD;
                    rx_st     <= R_ACK;
                end
                R_ACK: if (rcnt == '0) begin
                    bus.ack_n <= 1'b1;
                    rx_st     <= R_WAIT;
                end else begin
                    rcnt <= rcnt - CNT_ONE;
                end
                R_WAIT: if (bus.obf_n) rx_st <= R_IDLE;
                default: rx_st <= R_IDLE;
            endcase
        end
    end

    // pa_dout is only loaded on acceptance; the jt8255 samples porta_din live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st       <= T_IDLE;
            tcnt        <= '0;
            saw_ibf     <= 1'b0;
            bus.stb_n   <= 1'b1;
            bus.pa_oe   <= 1'b0;
            bus.pa_dout <= '0;
        end else begin
            case (tx_st)
                T_IDLE: if (bus.tx_valid && bus.tx_ready) begin
                    bus.pa_dout <= bus.tx_data;
                    bus.pa_oe   <= 1'b1;
                    bus.stb_n   <= 1'b0;
                    tcnt        <= STB_LOAD;
                    tx_st       <= T_STB;
                end
                T_STB: if (tcnt == '0) begin
                    bus.stb_n <= 1'b1;
                    saw_ibf   <= 1'b0;
                    tx_st     <= T_HOLD;
                end else begin
                    tcnt <= tcnt - CNT_ONE;
                end
                T_HOLD: begin
                    if (bus.ibf) saw_ibf <= 1'b1;
                    if (saw_ibf && !bus.ibf) begin
                        bus.pa_oe <= 1'b0;
                        tx_st     <= T_IDLE;
                    end
                end
                default: tx_st <= T_IDLE;
            endcase
        end
    end
endmodule
